// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: widths, the NOP encoding, the reset fetch
// address and the {instr, pc} packet handed from fetch to decode.
package pipe_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0]    RESET_PC  = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order FIFO with synchronous flush. Used both as the fetched
// instruction buffer and as the queue of PCs for requests still in flight.
// Only pointers and count are reset; the storage array is plain data.
module fetch_fifo
  import pipe_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = logic [31:0],
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  T              din,
  input  logic          pop,
  output T              dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  T              mem_q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          push_ok;
  logic          pop_ok;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  // flush wins over push and pop in the same cycle
  assign push_ok = push & ~flush & ~full;
  assign pop_ok  = pop & ~flush & ~empty;

  assign dout  = mem_q[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // storage write
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr] <= din;
    end
  end

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // The credit scheme upstream keeps this FIFO from ever overflowing.
  a_no_push_on_full: assert property (
    @(posedge clk) disable iff (!reset) !(push && full && !flush)
  );

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues word reads to an in-order memory
// of arbitrary latency, buffers returned words and hands {instr, pc} to
// decode. Credits (buffered + in-flight) are capped at BUF_DEPTH so the
// buffer can never overflow. A redirect flushes the buffer and marks every
// outstanding response as stale so it is discarded on arrival.
module fetch_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = pipe_pkg::RESET_PC,
  parameter int              BUF_DEPTH = 2,
  parameter int              IMEM_AW   = 10
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_rvalid,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               id_ready,
  output logic               id_valid,
  output logic [31:0]        id_instr,
  output logic [XLEN-1:0]    id_pc
);
  import pipe_pkg::*;

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int SW = CW + 1;

  logic [XLEN-1:0] pc_p0;
  logic [CW-1:0]   inflight_p0;
  logic [CW-1:0]   drop_p0;

  logic [XLEN-1:0] tag_head;
  logic            tag_full;
  logic            tag_empty;
  logic [CW-1:0]   tag_count;

  fetch_pkt_t      push_pkt_p1;
  fetch_pkt_t      head_p1;
  logic            buf_full;
  logic            buf_empty;
  logic [CW-1:0]   buf_count;

  logic            vld_p1;
  logic            pop;
  logic            drop_now;
  logic            push_rsp;
  logic [SW-1:0]   credits_used;
  logic            credit_ok;
  logic            unused_ok;

  // Decode-side handshake; a redirect cycle never delivers.
  assign vld_p1   = ~buf_empty;
  assign id_valid = vld_p1 & ~redirect_valid;
  assign id_instr = vld_p1 ? head_p1.instr : NOP_INSTR;
  assign id_pc    = vld_p1 ? head_p1.pc : '0;
  assign pop      = id_valid & id_ready;

  // A pop this cycle frees a slot, so request and pop may overlap.
  assign credits_used = SW'(buf_count) + SW'(inflight_p0);
  assign credit_ok    = credits_used < (SW'(BUF_DEPTH) + SW'(pop));
  assign imem_req     = reset & ~redirect_valid & credit_ok;
  assign imem_addr    = pc_p0[IMEM_AW+1:2];

  // Responses are stale while drop_p0 is nonzero or a redirect is underway.
  assign drop_now = imem_rvalid & (redirect_valid | (drop_p0 != '0));
  assign push_rsp = imem_rvalid & ~drop_now;

  assign push_pkt_p1.instr = imem_rdata;
  assign push_pkt_p1.pc    = tag_head;

  // ---- stage 0: PC generation and outstanding-request tracking ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_p0       <= RESET_PC;
      inflight_p0 <= '0;
      drop_p0     <= '0;
    end else begin
      if (redirect_valid) begin
        pc_p0 <= redirect_pc & ~XLEN'(3);
      end else if (imem_req) begin
        pc_p0 <= pc_p0 + XLEN'(4);
      end
      inflight_p0 <= inflight_p0 + CW'(imem_req) - CW'(imem_rvalid);
      if (redirect_valid) begin
        drop_p0 <= inflight_p0 - CW'(imem_rvalid);
      end else if (drop_now) begin
        drop_p0 <= drop_p0 - CW'(1);
      end
    end
  end

  // PCs of live requests, matched in order against returning data
  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .T     (logic [XLEN-1:0])
  ) u_tag_q (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (imem_req),
    .din   (pc_p0),
    .pop   (push_rsp),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  // ---- stage 1: fetched-instruction buffer feeding decode ----
  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .T     (fetch_pkt_t)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push_rsp),
    .din   (push_pkt_p1),
    .pop   (pop),
    .dout  (head_p1),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

  assign unused_ok = ^{buf_full, tag_full, tag_count};

  // Every accepted response must have a matching live request PC.
  a_tag_present: assert property (
    @(posedge clk) disable iff (!reset) !(push_rsp && tag_empty)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: an in-order memory model with selectable latency,
// an expected-stream scoreboard filled by the driver and a monitor that
// checks every accepted {instr, pc} against it.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  int tests  = 0;
  int failed = 0;

  fetch_stage #(
    .XLEN      (32),
    .RESET_PC  (32'h0),
    .BUF_DEPTH (2),
    .IMEM_AW   (10)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
  );

  always #5 clk = ~clk;

  // memory model: fixed-latency in-order pipeline, cleared by the same reset
  logic [31:0] mem [1024];
  int          lat = 1;
  logic        pv [1:4];
  logic [31:0] pd [1:4];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k <= 4; k++) begin
        pv[k] <= 1'b0;
        pd[k] <= '0;
      end
    end else begin
      pv[1] <= imem_req;
      pd[1] <= mem[imem_addr];
      for (int k = 2; k <= 4; k++) begin
        pv[k] <= pv[k-1];
        pd[k] <= pd[k-1];
      end
    end
  end

  assign imem_rvalid = pv[lat];
  assign imem_rdata  = pd[lat];

  // reference model: the program stream decode should see, in order
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] model_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refill();
    while (expq.size() < 8) begin
      expq.push_back('{instr: mem[model_pc[11:2]], pc: model_pc});
      model_pc = model_pc + 32'd4;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    refill();
  endtask

  task automatic restart_stream(input logic [31:0] tgt);
    expq.delete();
    model_pc = tgt & 32'hFFFF_FFFC;
    refill();
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    restart_stream(tgt);
    step();
    redirect_valid = 1'b0;
  endtask

  // assert reset mid-cycle, check outputs clear at once, release after a few edges
  task automatic do_reset(input int new_lat);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    expq.delete();
    #1;
    chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    repeat (2) @(posedge clk);
    lat      = new_lat;
    id_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    restart_stream(32'h0);
  endtask

  // first request right after release; first delivery two edges later
  task automatic check_startup();
    #1;
    chk("start_req", {31'b0, imem_req}, 32'd1);
    chk("start_addr", {22'b0, imem_addr}, 32'd0);
    chk("start_valid_c0", {31'b0, id_valid}, 32'd0);
    step(); #1;
    chk("start_valid_c1", {31'b0, id_valid}, 32'd0);
    step(); #1;
    chk("start_valid_c2", {31'b0, id_valid}, 32'd1);
    chk("start_pc_c2", id_pc, 32'd0);
  endtask

  // monitor: pops the scoreboard on every accepted transfer
  logic        hold_prev = 1'b0;
  logic [31:0] prev_pc;
  logic [31:0] prev_instr;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (redirect_valid) begin
          chk("redir_id_valid", {31'b0, id_valid}, 32'd0);
          chk("redir_imem_req", {31'b0, imem_req}, 32'd0);
        end else if (hold_prev) begin
          chk("hold_valid", {31'b0, id_valid}, 32'd1);
          chk("hold_pc", id_pc, prev_pc);
          chk("hold_instr", id_instr, prev_instr);
        end
        if (id_valid && id_ready) begin
          if (expq.size() == 0) begin
            chk("sb_unexpected_delivery", id_pc, 32'hxxxx_xxxx);
          end else begin
            e = expq.pop_front();
            chk("sb_pc", id_pc, e.pc);
            chk("sb_instr", id_instr, e.instr);
          end
        end
        hold_prev  = id_valid && !id_ready && !redirect_valid;
        prev_pc    = id_pc;
        prev_instr = id_instr;
      end else begin
        hold_prev = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;

    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[2] = 32'h0;
    model_pc = 32'h0;

    // streaming from reset with 1-cycle memory, one instruction per cycle
    @(posedge clk); #1;
    do_reset(1);
    check_startup();
    for (int i = 0; i < 6; i++) begin
      step(); #1;
      chk("stream_valid", {31'b0, id_valid}, 32'd1);
    end
    repeat (4) step();

    // stall at pc 8 (the NOP word) for five cycles
    do_reset(1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(); #1;
      if (id_valid && id_pc == 32'd8) found = 1'b1;
    end
    chk("stall_reach_pc8", {31'b0, found}, 32'd1);
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); #1;
      chk("stall_pc", id_pc, 32'd8);
      chk("stall_instr_nop", id_instr, 32'd0);
      chk("stall_no_req", {31'b0, imem_req}, 32'd0);
    end
    id_ready = 1'b1;
    repeat (10) step();

    // redirect to 0x40 with 3-cycle memory and requests in flight
    do_reset(3);
    repeat (6) step();
    do_redirect(32'h40);
    repeat (14) step();

    // redirect landing on a response cycle, unaligned target
    do_reset(1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(); #1;
      if (imem_rvalid) found = 1'b1;
    end
    chk("rvalid_seen", {31'b0, found}, 32'd1);
    do_redirect(32'h43);
    repeat (10) step();

    // reset with a full buffer, then restart from RESET_PC
    repeat (3) step();
    id_ready = 1'b0;
    repeat (3) step();
    #1;
    chk("pre_reset_valid", {31'b0, id_valid}, 32'd1);
    do_reset(1);
    check_startup();
    repeat (6) step();

    // pc wrap-around across the top of the address space
    do_redirect(32'hFFFF_FFF8);
    repeat (10) step();

    // randomized traffic for each memory latency
    for (int l = 1; l <= 3; l++) begin
      do_reset(l);
      for (int c = 0; c < 300; c++) begin
        step();
        id_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 19) == 0) do_redirect($urandom);
      end
      id_ready = 1'b1;
      repeat (8) step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
